// File: rtl/bus_master_port.sv
// Master-side bus port: takes a parallel command from the core, requests the
// arbiter, presents the slave id serially, then runs a bit-serial address /
// data transfer and reports completion to both the core and the arbiter.
module bus_master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [1:0]            cmd_slave,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_request,
    output logic                  m_slave_sel,
    input  logic                  m_grant,
    input  logic                  arbiter_busy,
    input  logic                  bus_busy,
    output logic                  trans_done,
    output logic                  bus_valid,
    output logic                  bus_data,
    output logic                  bus_mode,
    input  logic                  s_ack,
    input  logic                  s_rvalid,
    input  logic                  s_rdata
);
    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    // Last count value before the wait state gives up: TIMEOUT cycles in state.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        SSEL1,
        WAIT_GRANT,
        ADDR,
        WDATA,
        ACK_WAIT,
        RWAIT,
        RDATA,
        DONE
    } state_t;

    state_t                  state;
    logic                    mode_q;
    logic [1:0]              slave_q;
    logic [ADDR_WIDTH-1:0]   addr_sh;
    logic [DATA_WIDTH-1:0]   wdata_sh;
    logic [DATA_WIDTH-1:0]   rdata_sh;
    logic [DATA_WIDTH-1:0]   rdata_next;
    logic [CNT_W-1:0]        bit_cnt;
    logic [7:0]              tmo_cnt;
    logic                    err_q;

    // Read bits arrive LSB first, so each new bit enters at the top and slides down.
    assign rdata_next = {s_rdata, rdata_sh[DATA_WIDTH-1:1]};

    // Transfer sequencer: command capture, arbitration handshake, serial shifting.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            mode_q   <= 1'b0;
            slave_q  <= 2'b00;
            addr_sh  <= '0;
            wdata_sh <= '0;
            rdata_sh <= '0;
            rd_data  <= '0;
            bit_cnt  <= '0;
            tmo_cnt  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        mode_q   <= cmd_write;
                        slave_q  <= cmd_slave;
                        addr_sh  <= cmd_addr;
                        wdata_sh <= cmd_wdata;
                        err_q    <= 1'b0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (!arbiter_busy && !bus_busy) state <= SSEL1;
                end
                SSEL1: begin
                    state <= WAIT_GRANT;
                end
                WAIT_GRANT: begin
                    if (m_grant) begin
                        bit_cnt <= '0;
                        state   <= ADDR;
                    end else if (!arbiter_busy && !bus_busy) begin
                        // Lost this round; arbiter is sampling again, so re-present the id.
                        state <= SSEL1;
                    end
                end
                ADDR: begin
                    if (!m_grant) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        addr_sh <= addr_sh >> 1;
                        if (bit_cnt == ADDR_LAST) begin
                            bit_cnt <= '0;
                            tmo_cnt <= '0;
                            state   <= mode_q ? WDATA : RWAIT;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                WDATA: begin
                    if (!m_grant) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        wdata_sh <= wdata_sh >> 1;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            tmo_cnt <= '0;
                            state   <= ACK_WAIT;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ACK_WAIT: begin
                    if (!m_grant) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else if (s_ack) begin
                        err_q <= 1'b0;
                        state <= DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RWAIT: begin
                    if (!m_grant) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else if (s_rvalid) begin
                        rdata_sh <= rdata_next;
                        bit_cnt  <= CNT_W'(1);
                        state    <= RDATA;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RDATA: begin
                    if (!m_grant || !s_rvalid) begin
                        // A gap in the read stream leaves rd_data as it was.
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        rdata_sh <= rdata_next;
                        if (bit_cnt == DATA_LAST) begin
                            rd_data <= rdata_next;
                            err_q   <= 1'b0;
                            state   <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are pure decodes of the registered state and latched command.
    always_comb begin
        cmd_ready   = 1'b0;
        m_request   = 1'b0;
        m_slave_sel = 1'b0;
        bus_valid   = 1'b0;
        bus_data    = 1'b0;
        bus_mode    = 1'b0;
        done        = 1'b0;
        trans_done  = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE:       cmd_ready = 1'b1;
            REQ: begin
                m_request   = 1'b1;
                m_slave_sel = slave_q[0];
            end
            SSEL1: begin
                m_request   = 1'b1;
                m_slave_sel = slave_q[1];
            end
            WAIT_GRANT: begin
                m_request   = 1'b1;
                m_slave_sel = slave_q[0];
            end
            ADDR: begin
                bus_valid = 1'b1;
                bus_data  = addr_sh[0];
                bus_mode  = mode_q;
            end
            WDATA: begin
                bus_valid = 1'b1;
                bus_data  = wdata_sh[0];
                bus_mode  = mode_q;
            end
            ACK_WAIT, RWAIT, RDATA: bus_mode = mode_q;
            DONE: begin
                bus_mode   = mode_q;
                done       = 1'b1;
                trans_done = 1'b1;
                err        = err_q;
            end
            default: cmd_ready = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_bus_master_port.sv
// Testbench for bus_master_port: plays the core, the arbiter and the slave,
// and compares the serial traffic and completion status with a simple model.
module tb_bus_master_port;
    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int TMO = 255;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [1:0]    cmd_slave = 2'b00;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          done;
    logic          err;
    logic [DW-1:0] rd_data;
    logic          m_request;
    logic          m_slave_sel;
    logic          m_grant = 1'b0;
    logic          arbiter_busy = 1'b0;
    logic          bus_busy = 1'b0;
    logic          trans_done;
    logic          bus_valid;
    logic          bus_data;
    logic          bus_mode;
    logic          s_ack = 1'b0;
    logic          s_rvalid = 1'b0;
    logic          s_rdata = 1'b0;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_rd = '0;

    bus_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_slave(cmd_slave), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .done(done), .err(err), .rd_data(rd_data),
        .m_request(m_request), .m_slave_sel(m_slave_sel), .m_grant(m_grant),
        .arbiter_busy(arbiter_busy), .bus_busy(bus_busy), .trans_done(trans_done),
        .bus_valid(bus_valid), .bus_data(bus_data), .bus_mode(bus_mode),
        .s_ack(s_ack), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    // Issue a command and walk it through request, slave select and grant.
    task automatic start_cmd(input logic wr, input logic [1:0] sl, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input int req_hold, input int lose_rounds);
        @(negedge sys_clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || m_request !== 1'b0 || bus_mode !== 1'b0 || rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL idle: ready=%b done=%b req=%b mode=%b rd=%h, want 1 0 0 0 %h",
                     cmd_ready, done, m_request, bus_mode, rd_data, exp_rd);
        end
        arbiter_busy = (req_hold > 0);
        bus_busy     = (req_hold > 0);
        cmd_valid = 1'b1; cmd_write = wr; cmd_slave = sl; cmd_addr = a; cmd_wdata = wd;
        @(negedge sys_clk);
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_slave = ~sl;
        cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
        for (int i = 0; i <= req_hold; i++) begin
            n_checks++;
            if (m_request !== 1'b1 || m_slave_sel !== sl[0] || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL req: req=%b sel=%b ready=%b, want 1 %b 0", m_request, m_slave_sel, cmd_ready, sl[0]);
            end
            if (i == req_hold) begin arbiter_busy = 1'b0; bus_busy = 1'b0; end
            @(negedge sys_clk);
        end
        for (int r = 0; r <= lose_rounds; r++) begin
            n_checks++;
            if (m_request !== 1'b1 || m_slave_sel !== sl[1]) begin
                n_fail++;
                $display("FAIL ssel1: req=%b sel=%b, want 1 %b", m_request, m_slave_sel, sl[1]);
            end
            arbiter_busy = 1'b1; bus_busy = 1'b1;
            @(negedge sys_clk);
            if (r < lose_rounds) begin
                for (int k = 0; k < 3; k++) begin
                    n_checks++;
                    if (m_request !== 1'b1 || m_slave_sel !== sl[0] || bus_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL wait_lost: req=%b sel=%b bv=%b, want 1 %b 0", m_request, m_slave_sel, bus_valid, sl[0]);
                    end
                    if (k == 2) begin arbiter_busy = 1'b0; bus_busy = 1'b0; end
                    @(negedge sys_clk);
                end
            end else begin
                n_checks++;
                if (m_request !== 1'b1 || m_slave_sel !== sl[0]) begin
                    n_fail++;
                    $display("FAIL wait_grant: req=%b sel=%b, want 1 %b", m_request, m_slave_sel, sl[0]);
                end
                m_grant = 1'b1;
                @(negedge sys_clk);
            end
        end
    endtask

    // Serve a granted write: collect the serial stream, ack after ack_delay idle cycles.
    task automatic finish_write(input logic [AW-1:0] a, input logic [DW-1:0] wd, input int ack_delay);
        logic [AW+DW-1:0] got;
        int nb = 0, idle = 0;
        bit seen = 0, mode_ok = 1;
        got = '0;
        n_checks++;
        if (m_request !== 1'b0) begin n_fail++; $display("FAIL req_drop: req=%b, want 0", m_request); end
        for (int c = 0; c < 3000 && !seen; c++) begin
            s_ack = 1'b0;
            if (done === 1'b1) seen = 1;
            else begin
                if (bus_valid === 1'b1) begin
                    if (nb < AW + DW) got[nb] = bus_data;
                    nb++;
                    if (bus_mode !== 1'b1) mode_ok = 0;
                    if (nb == 2) s_ack = 1'b1;   // stray ack during ADDR must be ignored
                end else begin
                    idle++;
                    if (idle == ack_delay) s_ack = 1'b1;
                end
                @(negedge sys_clk);
            end
        end
        n_checks++;
        if (!seen || err !== 1'b0 || trans_done !== 1'b1 || bus_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_done: seen=%0d err=%b td=%b mode=%b, want 1 0 1 1", seen, err, trans_done, bus_mode);
        end
        n_checks++;
        if (nb != AW + DW || got !== {wd, a} || !mode_ok) begin
            n_fail++;
            $display("FAIL wr_serial: bits=%0d stream=%h mode_ok=%0d, want %0d %h 1", nb, got, mode_ok, AW + DW, {wd, a});
        end
        m_grant = 1'b0; arbiter_busy = 1'b0; bus_busy = 1'b0;
    endtask

    // Serve a granted read: return rd_val after rdelay idle cycles, or never if timing out.
    task automatic finish_read(input logic [AW-1:0] a, input logic [DW-1:0] rd_val, input int rdelay, input bit to);
        logic [AW-1:0] got;
        int nb = 0, idle = 0, k = 0;
        bit seen = 0;
        got = '0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            s_rvalid = 1'b0; s_rdata = 1'b0;
            if (done === 1'b1) seen = 1;
            else begin
                if (bus_valid === 1'b1) begin
                    if (nb < AW) got[nb] = bus_data;
                    nb++;
                end else begin
                    idle++;
                    if (!to && idle >= rdelay && k < DW) begin
                        s_rvalid = 1'b1; s_rdata = rd_val[k]; k++;
                    end
                end
                @(negedge sys_clk);
            end
        end
        if (!to) exp_rd = rd_val;
        n_checks++;
        if (nb != AW || got !== a) begin
            n_fail++;
            $display("FAIL rd_addr: bits=%0d addr=%h, want %0d %h", nb, got, AW, a);
        end
        n_checks++;
        if (!seen || err !== to || trans_done !== 1'b1 || bus_mode !== 1'b0 || rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL rd_done: seen=%0d err=%b td=%b mode=%b rd=%h, want 1 %b 1 0 %h",
                     seen, err, trans_done, bus_mode, rd_data, to, exp_rd);
        end
        n_checks++;
        if (idle != (to ? TMO : rdelay - 1 + DW)) begin
            n_fail++;
            $display("FAIL rd_wait: cycles=%0d, want %0d", idle, to ? TMO : rdelay - 1 + DW);
        end
        m_grant = 1'b0; arbiter_busy = 1'b0; bus_busy = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge sys_clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || m_request !== 1'b0 || m_slave_sel !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
            trans_done !== 1'b0 || bus_valid !== 1'b0 || bus_data !== 1'b0 || bus_mode !== 1'b0 || rd_data !== '0) begin
            n_fail++;
            $display("FAIL reset: ready=%b req=%b sel=%b done=%b err=%b td=%b bv=%b bd=%b mode=%b rd=%h, want 1 and rest 0",
                     cmd_ready, m_request, m_slave_sel, done, err, trans_done, bus_valid, bus_data, bus_mode, rd_data);
        end
        sys_rst_n = 1'b1;
    endtask

    task automatic test_write();
        start_cmd(1'b1, 2'b10, 12'h5A3, 8'hC4, 0, 0);
        finish_write(12'h5A3, 8'hC4, 2);
    endtask

    task automatic test_read();
        start_cmd(1'b0, 2'b01, 12'h010, 8'h00, 0, 0);
        finish_read(12'h010, 8'h3E, 1, 0);
    endtask

    task automatic test_contention();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = AW'($urandom); d = DW'($urandom);
        start_cmd(1'b1, 2'b11, a, d, 2, 1);
        finish_write(a, d, 1);
    endtask

    task automatic test_read_timeout();
        start_cmd(1'b0, 2'b00, 12'hABC, 8'h00, 0, 0);
        finish_read(12'hABC, 8'h00, 1, 1);
    endtask

    task automatic test_grant_drop();
        int nb = 0;
        bit seen = 0;
        start_cmd(1'b1, 2'b01, 12'hFFF, 8'hFF, 0, 0);
        for (int c = 0; c < 100 && !seen; c++) begin
            if (done === 1'b1) seen = 1;
            else begin
                if (bus_valid === 1'b1) nb++;
                if (nb == 5) m_grant = 1'b0;
                @(negedge sys_clk);
            end
        end
        n_checks++;
        if (!seen || nb != 5 || err !== 1'b1 || trans_done !== 1'b1 || bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL grant_drop: seen=%0d addr_cycles=%0d err=%b td=%b bv=%b, want 1 5 1 1 0", seen, nb, err, trans_done, bus_valid);
        end
        arbiter_busy = 1'b0; bus_busy = 1'b0;
        @(negedge sys_clk);
        n_checks++;
        if (bus_valid !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL grant_drop_after: bv=%b done=%b ready=%b, want 0 0 1", bus_valid, done, cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic          wr;
            logic [1:0]    sl;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            wr = 1'($urandom); sl = 2'($urandom); a = AW'($urandom); d = DW'($urandom);
            start_cmd(wr, sl, a, d, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
            if (wr) finish_write(a, d, int'($urandom_range(1, 4)));
            else    finish_read(a, d, int'($urandom_range(1, 4)), 0);
        end
    endtask

    task automatic test_reset_mid_addr();
        bit td_seen = 0;
        start_cmd(1'b1, 2'b10, 12'h5A3, 8'hC4, 0, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        exp_rd = '0;
        n_checks++;
        if (cmd_ready !== 1'b1 || m_request !== 1'b0 || bus_valid !== 1'b0 || bus_data !== 1'b0 || bus_mode !== 1'b0 ||
            done !== 1'b0 || trans_done !== 1'b0 || err !== 1'b0 || rd_data !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: ready=%b req=%b bv=%b bd=%b mode=%b done=%b td=%b err=%b rd=%h, want 1 and rest 0",
                     cmd_ready, m_request, bus_valid, bus_data, bus_mode, done, trans_done, err, rd_data);
        end
        m_grant = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (trans_done !== 1'b0 || cmd_ready !== 1'b1) td_seen = 1;
            @(negedge sys_clk);
        end
        n_checks++;
        if (td_seen) begin
            n_fail++;
            $display("FAIL reset_mid_after: trans_done or busy after reset seen=%0d, want 0", td_seen);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_read_timeout();
        test_grant_drop();
        test_back_to_back();
        test_reset_mid_addr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
